// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction ROM request channel plus the ID-facing
// instruction channel. The fetch block takes the master modport.
interface inst_fetch_if;
    // ROM channel: a request transfers in the cycle where rom_en and rom_ready are
    // both 1, and rom_addr stays stable while rom_en=1. ID channel: addr/inst are
    // consumed in the cycle where inst_valid=1 and stall=0.
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic        rom_ready;
    logic [31:0] rom_data;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        inst_valid;
    logic [1:0]  fsm_state;

    modport master (
        input  stall, branch_flag, branch_addr, rom_ready, rom_data,
        output rom_en, rom_addr, addr, inst, inst_valid, fsm_state
    );

    modport slave (
        output stall, branch_flag, branch_addr, rom_ready, rom_data,
        input  rom_en, rom_addr, addr, inst, inst_valid, fsm_state
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding ROM request feeding a 2-entry
// {addr, inst} FIFO towards ID, with branch flush and late-response discard.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] fifo_addr_q [2];
    logic [31:0] fifo_inst_q [2];
    logic        head_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;

    logic        valid;
    logic        pop;
    logic        br_take;
    logic        complete;
    logic        push;
    logic        reserve;
    logic        wr_idx;
    logic [31:0] pc_eff;

    always_comb begin
        valid    = (count_q != 2'd0);
        pop      = valid && !bus.stall;
        br_take  = pop && bus.branch_flag;
        complete = (state_q != IDLE) && bus.rom_ready;
        push     = complete && (state_q == FETCH) && !br_take;
        pc_eff   = br_take ? bus.branch_addr : pc_q;
        wr_idx   = head_q ^ count_q[0];

        count_d = count_q;
        if (br_take) begin
            count_d = 2'd0;
        end else if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        // A new request is only issued if its response is guaranteed a slot.
        reserve = (count_d <= 2'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                fifo_addr_q[k] <= 32'd0;
                fifo_inst_q[k] <= 32'd0;
            end
        end else begin
            count_q <= count_d;
            if (br_take) begin
                head_q <= 1'b0;
            end else if (pop) begin
                head_q <= ~head_q;
            end
            if (push) begin
                fifo_addr_q[wr_idx] <= req_addr_q;
                fifo_inst_q[wr_idx] <= bus.rom_data;
            end

            case (state_q)
                IDLE: begin
                    if (reserve) begin
                        state_q    <= FETCH;
                        req_addr_q <= pc_eff;
                        pc_q       <= pc_eff + 32'd4;
                    end else begin
                        pc_q <= pc_eff;
                    end
                end
                FETCH: begin
                    if (complete) begin
                        if (reserve) begin
                            req_addr_q <= pc_eff;
                            pc_q       <= pc_eff + 32'd4;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (br_take) begin
                        // Response of the live request is now stale; keep rom_addr stable.
                        state_q <= DROP;
                        pc_q    <= bus.branch_addr;
                    end
                end
                DROP: begin
                    if (complete) begin
                        state_q    <= FETCH;
                        req_addr_q <= pc_eff;
                        pc_q       <= pc_eff + 32'd4;
                    end else begin
                        pc_q <= pc_eff;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rom_en     = (state_q != IDLE);
    assign bus.rom_addr   = req_addr_q;
    assign bus.inst_valid = valid;
    assign bus.addr       = valid ? fifo_addr_q[head_q] : 32'd0;
    assign bus.inst       = valid ? fifo_inst_q[head_q] : 32'd0;
    assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: randomized ROM latency, stall and branches checked
// against a program-flow model of which addresses ID must see, in order.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if ifc ();
    inst_fetch_if ifc_w ();

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign ifc.rom_data   = rom_word(ifc.rom_addr);
    assign ifc_w.rom_data = rom_word(ifc_w.rom_addr);

    inst_fetch #(.RESET_PC(RESET_PC)) dut   (.clk(clk), .rst(rst), .bus(ifc));
    inst_fetch #(.RESET_PC(WRAP_PC))  dut_w (.clk(clk), .rst(rst), .bus(ifc_w));

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    int          n_pop = 0;
    int          no_pop = 0;

    // sampled outputs and previous-cycle history
    logic        s_iv, s_en;
    logic [31:0] s_addr, s_inst, s_raddr;
    logic        p_en, p_ready, p_iv, p_stall;
    logic [31:0] p_raddr, p_addr;
    logic        last_ready;

    // stimulus policy
    int stall_pct = 0;
    int br_pct = 0;
    int lat_min = 0;
    int lat_max = 0;
    bit rand_idle = 1'b0;

    // ROM responder state
    bit req_active = 1'b0;
    int req_age = 0;
    int req_lat = 0;

    // directed branch trigger
    bit          trig_en = 1'b0;
    bit          trig_hit = 1'b0;
    logic [31:0] trig_addr, trig_tgt;
    logic        trig_ready, trig_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: sample at negedge, check, then drive the inputs for the next posedge.
    task automatic cycle();
        logic        do_stall, do_br, rdy;
        logic [31:0] tgt;
        @(negedge clk);
        s_iv    = ifc.inst_valid;
        s_addr  = ifc.addr;
        s_inst  = ifc.inst;
        s_en    = ifc.rom_en;
        s_raddr = ifc.rom_addr;

        if (p_en && p_ready) req_active = 1'b0;
        else if (req_active) req_age++;
        if (s_en && !req_active) begin
            req_active = 1'b1;
            req_age    = 0;
            req_lat    = $urandom_range(lat_min, lat_max);
        end

        if (!s_iv) begin
            check_eq("nop_addr", s_addr, 32'd0);
            check_eq("nop_inst", s_inst, 32'd0);
        end else begin
            check_eq("addr", s_addr, exp_q[0]);
            check_eq("inst", s_inst, rom_word(exp_q[0]));
        end
        if (p_en && !p_ready) begin
            check_eq("rom_en_hold", 32'(s_en), 32'd1);
            check_eq("rom_addr_hold", s_raddr, p_raddr);
        end
        if (p_iv && p_stall) check_eq("stall_hold", s_addr, p_addr);

        do_stall = ($urandom_range(0, 99) < stall_pct);
        do_br    = ($urandom_range(0, 99) < br_pct);
        tgt      = $urandom & 32'h0000_3FFC;
        if (req_active) rdy = (req_age >= req_lat);
        else rdy = rand_idle ? 1'($urandom_range(0, 1)) : 1'b0;
        if (trig_en && s_iv && s_addr == trig_addr && !do_stall) begin
            do_br      = 1'b1;
            tgt        = trig_tgt;
            trig_en    = 1'b0;
            trig_hit   = 1'b1;
            trig_ready = rdy;
            trig_busy  = s_en;
        end

        ifc.stall       = do_stall;
        ifc.branch_flag = do_br;
        ifc.branch_addr = tgt;
        ifc.rom_ready   = rdy;
        last_ready      = rdy;

        // Program-flow model: every consumed instruction names its successor.
        if (s_iv && !do_stall) begin
            void'(exp_q.pop_front());
            exp_q.push_back(do_br ? tgt : s_addr + 32'd4);
            n_pop++;
            no_pop = 0;
        end else if (!do_stall) begin
            no_pop++;
            if (no_pop > 40) begin
                check_eq("progress", no_pop, 40);
                no_pop = 0;
            end
        end

        p_en    = s_en;
        p_ready = rdy;
        p_raddr = s_raddr;
        p_iv    = s_iv;
        p_stall = do_stall;
        p_addr  = s_addr;
    endtask

    // Reset with branch_flag and rom_ready high: both must be ignored.
    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b0;
        ifc.stall       = 1'b0;
        ifc.branch_flag = 1'b1;
        ifc.branch_addr = 32'h0000_0300;
        ifc.rom_ready   = 1'b1;
        #1;
        check_eq("rst_rom_en", 32'(ifc.rom_en), 32'd0);
        check_eq("rst_valid", 32'(ifc.inst_valid), 32'd0);
        check_eq("rst_addr", ifc.addr, 32'd0);
        check_eq("rst_inst", ifc.inst, 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        req_active = 1'b0;
        p_en = 1'b0; p_ready = 1'b0; p_iv = 1'b0; p_stall = 1'b0;
        no_pop = 0;
        rst = 1'b1;
    endtask

    task automatic mid_reset();
        bit found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            cycle();
            if (s_en && !last_ready) found = 1'b1;
        end
        check_eq("areset_setup", 32'(found), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("areset_rom_en", 32'(ifc.rom_en), 32'd0);
        check_eq("areset_valid", 32'(ifc.inst_valid), 32'd0);
        check_eq("areset_addr", ifc.addr, 32'd0);
        check_eq("areset_inst", ifc.inst, 32'd0);
        do_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        rst = 1'b0;
        ifc.stall = 1'b0; ifc.branch_flag = 1'b0; ifc.branch_addr = 32'd0; ifc.rom_ready = 1'b0;
        ifc_w.stall = 1'b0; ifc_w.branch_flag = 1'b0; ifc_w.branch_addr = 32'd0; ifc_w.rom_ready = 1'b1;

        // Zero-wait ROM: address stream, 1-cycle latency, wrap on second instance.
        lat_min = 0; lat_max = 0;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check_eq("seq_rom_addr", s_raddr, RESET_PC + 32'(4 * (k - 1)));
            check_eq("seq_valid", 32'(s_iv), (k >= 2) ? 32'd1 : 32'd0);
            if (k <= 3) check_eq("wrap_rom_addr", ifc_w.rom_addr, WRAP_PC + 32'(4 * (k - 1)));
        end
        pops0 = n_pop;
        repeat (20) cycle();
        check_eq("throughput", n_pop - pops0, 20);

        // Stall for 5 cycles (branch_flag also high, must be ignored).
        stall_pct = 100; br_pct = 100;
        repeat (5) cycle();
        stall_pct = 0; br_pct = 0;
        cycle();
        check_eq("stall_rom_idle", 32'(s_en), 32'd0);
        check_eq("stall_valid", 32'(s_iv), 32'd1);
        repeat (10) cycle();

        // Branch at 0x10 while the 0x14 request waits on a 3-cycle ROM.
        lat_min = 2; lat_max = 2;
        do_reset();
        trig_addr = 32'h10; trig_tgt = 32'h100; trig_hit = 1'b0; trig_en = 1'b1;
        for (int i = 0; i < 60 && !trig_hit; i++) cycle();
        check_eq("drop_trig", 32'(trig_hit), 32'd1);
        check_eq("drop_setup_ready", 32'(trig_ready), 32'd0);
        check_eq("drop_setup_busy", 32'(trig_busy), 32'd1);
        cycle();
        check_eq("drop_hold_addr", s_raddr, 32'h14);
        check_eq("drop_flushed", 32'(s_iv), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_en && s_raddr != 32'h14) break;
        end
        check_eq("drop_redirect", s_raddr, 32'h100);
        repeat (12) cycle();

        // Branch in the same cycle as a ready response.
        lat_min = 0; lat_max = 0;
        do_reset();
        trig_addr = 32'h20; trig_tgt = 32'h200; trig_hit = 1'b0; trig_en = 1'b1;
        for (int i = 0; i < 60 && !trig_hit; i++) cycle();
        check_eq("same_trig", 32'(trig_hit), 32'd1);
        check_eq("same_setup_ready", 32'(trig_ready), 32'd1);
        cycle();
        check_eq("same_rom_addr", s_raddr, 32'h200);
        check_eq("same_rom_en", 32'(s_en), 32'd1);
        check_eq("same_flushed", 32'(s_iv), 32'd0);
        repeat (8) cycle();

        // Random soak, async reset mid-request, more soak.
        lat_min = 0; lat_max = 3; stall_pct = 30; br_pct = 10; rand_idle = 1'b1;
        repeat (1500) cycle();
        mid_reset();
        cycle();
        check_eq("post_reset_rom_addr", s_raddr, RESET_PC);
        check_eq("post_reset_rom_en", 32'(s_en), 32'd1);
        repeat (500) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
